a2d_sequencer: RTL and testbench
================================

# a2d_sequencer

Autonomous round-robin sequencer for the eBike's 8-channel SPI A2D converter. It periodically converts battery voltage, motor current, brake lever and pedal torque, and presents each as a held 12-bit result. These results are the `batt`, `curr` and `torque` inputs consumed by sensor conditioning. The block owns the single SPI bus and its own SPI frame engine.

## Interface
Parameters:
- FAST_SIM, default 1. 1 selects a 2^11-clk conversion interval for simulation; 0 selects 2^14 clks.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- MISO  input  1  serial data from A2D
- SS_n  output  1  A2D slave select, active low
- SCLK  output  1  SPI clock, idle high
- MOSI  output  1  serial data to A2D
- batt  output  12  latest channel 0 result
- curr  output  12  latest channel 1 result
- brake  output  12  latest channel 3 result
- torque  output  12  latest channel 4 result
- smpl_rdy  output  1  one-clk pulse when any result register updates
- smpl_chnl  output  2  slot index (0 = batt, 1 = curr, 2 = brake, 3 = torque) of the last update; valid with smpl_rdy

## Operation
- Interval timer: free-running counter, 11 bits (FAST_SIM=1) or 14 bits (FAST_SIM=0). Expiry is defined as the counter being all ones.
- Expiry in IDLE starts one conversion of the current slot. Expiry while busy is dropped, not queued.
- Slot order: 0→1→2→3→0, mapping to A2D channels 0, 1, 3, 4. The slot pointer advances at DONE.
- Command word is {2'b00, chnl[2:0], 11'h000}: 16'h0000, 16'h0800, 16'h1800, 16'h2000 for slots 0–3.
- Conversion FSM:
  - IDLE → CMD on expiry. CMD sends frame 1, the command; MISO data is ignored.
  - CMD → GAP at frame end. GAP holds SS_n high for 2 clks.
  - GAP → READ. READ sends frame 2 with the same command word.
  - READ → DONE at frame end. DONE loads MISO word bits [11:0] into the slot's result register and pulses smpl_rdy.
  - DONE → IDLE.
- Two frames are required because the A2D returns the conversion for the channel addressed in the previous frame.
- Frame engine:
  - 5-bit divider, SCLK = div[4]. The divider is preset to 5'b10111 when SS_n falls.
  - MOSI = shift[15], where shift is loaded with the command as SS_n falls.
  - Rising SCLK edge (div 01111→10000): MISO is sampled into a 1-bit shadow.
  - Following falling-edge point (div 11111→00000): shift is shifted left with the shadow bit inserted.
  - On the 16th falling-edge point, SCLK stays high, SS_n rises and the final shift completes. The shift register then holds the full received word.
- Upper 4 bits of the received word are discarded.
- Result registers hold their values between updates and are never cleared except by reset.

## Timing
- Reset values:
  - SS_n=1, SCLK=1, MOSI=0.
  - All result registers 12'h000.
  - smpl_rdy=0, smpl_chnl=0.
  - FSM in IDLE, slot pointer 0, timer 0.
- First expiry occurs 2^11−1 clks (FAST_SIM=1) after reset release.
- Frame edge timing:
  - First SCLK fall: 8 clks after SS_n fall.
  - SCLK period: 32 clks, 50% duty.
  - 16th rising edge: 504 clks after SS_n fall.
  - SS_n rise: 520 clks after SS_n fall.
- Conversion: SS_n falls 1 clk after expiry. Total length is 520 + 2 + 520 clks, plus 1 clk of DONE.
- smpl_rdy asserts in the clk after frame-2 SS_n rise, concurrent with the result register update. It lasts exactly 1 clk.
- SCLK and SS_n are registered outputs with no glitches. SCLK never toggles while SS_n is high.
- Asserting rst_n low mid-frame forces SS_n=1 and SCLK=1 immediately (asynchronous). Partial data is discarded and the sequence restarts at slot 0.
- The interval timer continues running during conversions; it is not restarted by them.

## Test plan
- Reset: hold rst_n low → all outputs at their reset values. No SCLK activity for the first 2046 clks after release.
- Single conversion: MISO model returns 16'hFA98 for frame 2 → MOSI frames carry 16'h0000 → batt=12'hA98 (upper nibble dropped), smpl_rdy pulses 1 clk with smpl_chnl=0, other results remain 0.
- Round-robin: run 5 intervals with distinct model values → commands seen are 16'h0000, 16'h0800, 16'h1800, 16'h2000, 16'h0000, and each value lands in the correct register in slot order.
- SPI edge timing: measure at the bench → first fall 8 clks after SS_n fall, 32-clk SCLK period, exactly 16 rises per frame, SS_n high 520 clks after fall, GAP of 2 clks with SS_n high.
- Reset mid-frame: assert rst_n during frame 2 of the curr conversion → SS_n/SCLK return high at once, curr stays 0, next conversion addresses channel 0.
- Bit-order check: model returns 16'h0555 then 16'h0AAA → curr reads 12'h555 and brake reads 12'hAAA, confirming MSB-first capture on rising edges.

Source files
------------

// File: rtl/a2d_sequencer.sv
// a2d_sequencer: autonomous round-robin sampler for the 8-channel SPI A2D.
// Every conversion interval one slot is converted with two SPI frames
// (address, then read-back) and the 12-bit result is held in its register.
//
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   MISO         serial data from the A2D
//   SS_n         A2D slave select, active low (registered)
//   SCLK         SPI clock, idles high (divider MSB)
//   MOSI         serial data to the A2D (shift register MSB)
//   batt         latest channel 0 result
//   curr         latest channel 1 result
//   brake        latest channel 3 result
//   torque       latest channel 4 result
//   smpl_rdy     one-clk pulse when a result register updates
//   smpl_chnl    slot index of the last update (0 batt, 1 curr, 2 brake, 3 torque)
module a2d_sequencer #(
  parameter int FAST_SIM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic        smpl_rdy,
  output logic [1:0]  smpl_chnl
);

  localparam int unsigned TMR_W  = (FAST_SIM != 0) ? 11 : 14;
  localparam int unsigned DIV_W  = 5;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned SLOT_W = 2;
  localparam int unsigned CHN_W  = 3;

  localparam logic [DIV_W-1:0] DIV_REST = 5'b10111;
  localparam logic [DIV_W-1:0] DIV_RISE = 5'b01111;
  localparam logic [DIV_W-1:0] DIV_FALL = 5'b11111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_GAP,
    S_READ,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q;
  logic [SLOT_W-1:0]   slot_q;
  logic                gap_q;
  logic [DIV_W-1:0]    div_q;
  logic [WORD_W-1:0]   shift_q;
  logic                shadow_q;
  logic                armed_q;
  logic [CNT_W-1:0]    bit_cnt_q;

  logic                expire_c;
  logic                frame_start_c;
  logic                done_c;
  logic                rise_pt_c;
  logic                fall_pt_c;
  logic                frame_end_c;
  logic [CHN_W-1:0]    chnl_c;
  logic [WORD_W-1:0]   cmd_c;

  // Free-running interval timer; conversions never restart it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_q + TMR_W'(1);
    end
  end

  assign expire_c = &tmr_q;

  // Slot to A2D channel mapping and command word.
  always_comb begin
    chnl_c = 3'd0;
    case (slot_q)
      2'd0:    chnl_c = 3'd0;
      2'd1:    chnl_c = 3'd1;
      2'd2:    chnl_c = 3'd3;
      default: chnl_c = 3'd4;
    endcase
  end

  assign cmd_c = {2'b00, chnl_c, 11'h000};

  // Frame engine edge points. The first fall of a frame precedes any rise,
  // so shifting is armed only once a MISO bit has been captured.
  assign rise_pt_c   = !SS_n && (div_q == DIV_RISE);
  assign fall_pt_c   = !SS_n && armed_q && (div_q == DIV_FALL);
  assign frame_end_c = fall_pt_c && (bit_cnt_q == CNT_W'(15));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and control decode.
  always_comb begin
    state_d       = state_q;
    frame_start_c = 1'b0;
    done_c        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (expire_c) begin
          state_d       = S_CMD;
          frame_start_c = 1'b1;
        end
      end
      S_CMD: begin
        if (frame_end_c) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q) begin
          state_d       = S_READ;
          frame_start_c = 1'b1;
        end
      end
      S_READ: begin
        if (frame_end_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Two-clk SS_n-high gap between the address and read-back frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= 1'b0;
    end else begin
      gap_q <= (state_q == S_GAP) ? ~gap_q : 1'b0;
    end
  end

  // SPI frame engine. The divider rests at 10111 while SS_n is high and
  // counts from the clk SS_n falls, putting the first SCLK fall 8 clks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SS_n      <= 1'b1;
      div_q     <= DIV_REST;
      shift_q   <= '0;
      shadow_q  <= 1'b0;
      armed_q   <= 1'b0;
      bit_cnt_q <= '0;
    end else if (frame_start_c) begin
      SS_n      <= 1'b0;
      div_q     <= DIV_REST + DIV_W'(1);
      shift_q   <= cmd_c;
      armed_q   <= 1'b0;
      bit_cnt_q <= '0;
    end else if (!SS_n) begin
      // The last fall point ends the frame with SCLK parked high.
      if (frame_end_c) begin
        SS_n  <= 1'b1;
        div_q <= DIV_REST;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
      if (rise_pt_c) begin
        shadow_q <= MISO;
        armed_q  <= 1'b1;
      end
      if (fall_pt_c) begin
        shift_q   <= {shift_q[WORD_W-2:0], shadow_q};
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
    end
  end

  assign SCLK = div_q[DIV_W-1];
  assign MOSI = shift_q[WORD_W-1];

  // Result capture, ready pulse and slot advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batt      <= '0;
      curr      <= '0;
      brake     <= '0;
      torque    <= '0;
      smpl_rdy  <= 1'b0;
      smpl_chnl <= '0;
      slot_q    <= '0;
    end else begin
      smpl_rdy <= done_c;
      if (done_c) begin
        smpl_chnl <= slot_q;
        slot_q    <= slot_q + SLOT_W'(1);
        case (slot_q)
          2'd0:    batt   <= shift_q[11:0];
          2'd1:    curr   <= shift_q[11:0];
          2'd2:    brake  <= shift_q[11:0];
          default: torque <= shift_q[11:0];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_a2d_sequencer.sv
// tb_a2d_sequencer: bench for a2d_sequencer. An A2D model answers each frame
// with the value of the channel addressed in the previous frame and measures
// SPI timing; expected results are queued at frame-2 start and popped by a
// scoreboard whenever smpl_rdy is seen.
module tb_a2d_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MISO = 1'b0;
  logic        SS_n, SCLK, MOSI;
  logic [11:0] batt, curr, brake, torque;
  logic        smpl_rdy;
  logic [1:0]  smpl_chnl;

  a2d_sequencer #(.FAST_SIM(1)) dut (
    .clk(clk), .rst_n(rst_n), .MISO(MISO), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .batt(batt), .curr(curr), .brake(brake), .torque(torque),
    .smpl_rdy(smpl_rdy), .smpl_chnl(smpl_chnl)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct packed {
    logic [1:0]  slot;
    logic [11:0] val;
  } exp_t;

  int          slot_chan [4] = '{0, 1, 3, 4};
  logic [15:0] analog [8];
  logic [11:0] ref_res [4];
  exp_t        exp_q [$];
  bit          rand_en = 1'b0;
  int          n_smpl = 0;

  function automatic logic [15:0] exp_cmd(input int frame);
    int s;
    s = (frame / 2) % 4;
    return {2'b00, 3'(slot_chan[s]), 11'h000};
  endfunction

  // A2D model and SPI timing monitor
  int          fs, frame_cnt, conv_cnt, rises;
  int          t0, t_last_rise, t_end, t_ss_rise, rel_cyc, last_conv_start;
  logic [2:0]  last_addr;
  logic [15:0] tx, rx;
  bit          prev_ss, prev_sclk, fall_seen, period_ok, first_frame, sclk_low_seen;

  initial begin : a2d_model
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fs = 0; frame_cnt = 0; conv_cnt = 0; last_addr = 3'd0;
        prev_ss = 1'b1; prev_sclk = 1'b1; first_frame = 1'b1;
        sclk_low_seen = 1'b0; rel_cyc = cyc; MISO = 1'b0;
      end else begin
        if (SS_n && !prev_ss) begin
          check_eq("ss_low_len", 32'(cyc - t0), 32'd520);
          check_eq("rises_per_frame", 32'(rises), 32'd16);
          check_eq("sclk_period_ok", 32'(period_ok), 32'd1);
          check_eq("mosi_cmd", 32'(rx), 32'(exp_cmd(frame_cnt)));
          last_addr = rx[13:11];
          t_end = cyc;
          if (frame_cnt % 2 == 1) begin
            t_ss_rise = cyc;
            conv_cnt++;
            if (rand_en) begin
              for (int i = 0; i < 8; i++) analog[i] = 16'($urandom);
            end
          end
          frame_cnt++;
        end else if (!SS_n && prev_ss) begin
          if (frame_cnt % 2 == 0) begin
            if (first_frame) check_eq("first_frame_delay", 32'(cyc - rel_cyc), 32'd2048);
            else             check_eq("interval", 32'(cyc - last_conv_start), 32'd2048);
            first_frame = 1'b0;
            last_conv_start = cyc;
          end else begin
            exp_t e;
            check_eq("gap_len", 32'(cyc - t_end), 32'd2);
            e.slot = 2'(conv_cnt % 4);
            e.val  = analog[slot_chan[conv_cnt % 4]][11:0];
            exp_q.push_back(e);
          end
          check_eq("sclk_idle_high", 32'(sclk_low_seen), 32'd0);
          fs++;
          t0 = cyc; rises = 0; fall_seen = 1'b0; period_ok = 1'b1; rx = '0;
          tx = analog[last_addr];
          MISO = tx[15];
        end else if (SS_n) begin
          if (!SCLK) sclk_low_seen = 1'b1;
        end else begin
          if (prev_sclk && !SCLK) begin
            if (!fall_seen) check_eq("first_fall", 32'(cyc - t0), 32'd8);
            fall_seen = 1'b1;
            if (rises < 16) MISO = tx[15 - rises];
          end else if (!prev_sclk && SCLK) begin
            rx = {rx[14:0], MOSI};
            if (rises > 0 && (cyc - t_last_rise) != 32) period_ok = 1'b0;
            rises++;
            t_last_rise = cyc;
          end
        end
        prev_ss = SS_n;
        prev_sclk = SCLK;
      end
    end
  end

  // Scoreboard: pops one expectation per smpl_rdy pulse
  initial begin : scoreboard
    bit   prev_rdy;
    exp_t e;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) ref_res[i] = 12'h000;
        exp_q.delete();
        prev_rdy = 1'b0;
      end else begin
        if (smpl_rdy) begin
          check_eq("rdy_one_clk", 32'(prev_rdy), 32'd0);
          check_eq("rdy_after_ss_rise", 32'(cyc - t_ss_rise), 32'd1);
          if (exp_q.size() == 0) begin
            check_eq("rdy_unexpected", 32'd1, 32'(exp_q.size()));
          end else begin
            e = exp_q.pop_front();
            check_eq("smpl_chnl", 32'(smpl_chnl), 32'(e.slot));
            ref_res[e.slot] = e.val;
          end
          check_eq("batt", 32'(batt), 32'(ref_res[0]));
          check_eq("curr", 32'(curr), 32'(ref_res[1]));
          check_eq("brake", 32'(brake), 32'(ref_res[2]));
          check_eq("torque", 32'(torque), 32'(ref_res[3]));
          n_smpl++;
        end
        prev_rdy = smpl_rdy;
      end
    end
  end

  task automatic wait_smpl(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (n_smpl < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (n_smpl < target) check_eq({"timeout_", tag}, 32'(n_smpl), 32'(target));
  endtask

  initial begin : main
    int base;
    int n;
    for (int i = 0; i < 8; i++) analog[i] = 16'($urandom);
    analog[0] = 16'hFA98;
    analog[1] = 16'h0555;
    analog[3] = 16'h0AAA;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ss_n", 32'(SS_n), 32'd1);
    check_eq("rst_sclk", 32'(SCLK), 32'd1);
    check_eq("rst_mosi", 32'(MOSI), 32'd0);
    check_eq("rst_results", 32'({batt, curr, brake, torque} != 48'h0), 32'd0);
    check_eq("rst_smpl_rdy", 32'(smpl_rdy), 32'd0);
    check_eq("rst_smpl_chnl", 32'(smpl_chnl), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Quiet period after release
    repeat (2046) @(posedge clk);
    #1;
    check_eq("quiet_frames", 32'(fs), 32'd0);
    check_eq("quiet_sclk", 32'(sclk_low_seen), 32'd0);

    // Directed values: upper nibble dropped, then bit-order patterns
    wait_smpl(1, 3 * 2048, "first");
    check_eq("batt_fa98", 32'(batt), 32'h0A98);
    check_eq("curr_still_0", 32'(curr), 32'd0);
    check_eq("first_chnl", 32'(smpl_chnl), 32'd0);
    wait_smpl(3, 3 * 2048, "bitorder");
    check_eq("curr_555", 32'(curr), 32'h0555);
    check_eq("brake_aaa", 32'(brake), 32'h0AAA);
    wait_smpl(4, 2 * 2048, "torque");

    // Random values across the slot wrap
    for (int i = 0; i < 8; i++) analog[i] = 16'($urandom);
    rand_en = 1'b1;
    wait_smpl(9, 6 * 2048, "random");

    // Fresh reset, then reset during frame 2 of the curr conversion
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    while (fs < 4 && n < 3 * 2048) begin
      @(posedge clk);
      n++;
    end
    check_eq("reach_curr_frame2", 32'(fs), 32'd4);
    repeat (200) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_ss_n", 32'(SS_n), 32'd1);
    check_eq("midrst_sclk", 32'(SCLK), 32'd1);
    check_eq("midrst_curr", 32'(curr), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    base = n_smpl;
    wait_smpl(base + 1, 3 * 2048, "after_rst");
    check_eq("after_rst_chnl", 32'(smpl_chnl), 32'd0);
    check_eq("after_rst_curr", 32'(curr), 32'd0);
    wait_smpl(base + 2, 2 * 2048, "after_rst_curr");
    check_eq("pending_exp", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
